// File: rtl/cache_arbiter_if.sv
// Bus bundle between the arbiter, the two cache requesters and the burst memory.
// The arbiter side uses 'master' (it masters the memory bus and answers the caches);
// the environment (caches + memory) uses 'slave'.
interface cache_arbiter_if;
  logic         icache_pmem_read;
  logic [31:0]  icache_pmem_address;
  logic [255:0] icache_pmem_rdata;
  logic         icache_pmem_resp;

  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [31:0]  dcache_pmem_address;
  logic [255:0] dcache_pmem_wdata;
  logic [255:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;

  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  modport master (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester cache arbiter: grants one 32-byte line transfer at a time to the
// icache or dcache and runs it as four 64-bit beats on the burst memory bus.
module cache_arbiter #(
  parameter bit DCACHE_PRIORITY = 1'b1  // 1: dcache wins a tie, 0: icache wins
) (
  input logic           clk,
  input logic           rst,   // asynchronous, active low
  cache_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;

  state_t       state_q;
  logic [1:0]   beat_q;
  logic [31:0]  addr_q;
  logic [255:0] wline_q;    // dcache write line latched at grant
  logic [255:0] line_q;     // read line under assembly
  logic [255:0] irdata_q;   // last completed icache line
  logic [255:0] drdata_q;   // last completed dcache read line
  logic         rd_q, wr_q, iresp_q, dresp_q;

  logic         d_req, gnt_i, gnt_d, gnt_dw;
  logic [255:0] line_d;

  // Grant decision used only while IDLE; a write beats a read on the dcache side
  always_comb begin
    d_req  = bus.dcache_pmem_read | bus.dcache_pmem_write;
    gnt_d  = d_req & (~bus.icache_pmem_read | DCACHE_PRIORITY);
    gnt_i  = bus.icache_pmem_read & ~gnt_d;
    gnt_dw = gnt_d & bus.dcache_pmem_write;
  end

  // Line buffer with the incoming beat merged into the slice selected by the counter
  always_comb begin
    line_d = line_q;
    line_d[{beat_q, 6'd0} +: 64] = bus.pmem_rdata;
  end

  // Transaction FSM; memory strobes and cache responses are registered here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      addr_q   <= '0;
      wline_q  <= '0;
      line_q   <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      iresp_q  <= 1'b0;
      dresp_q  <= 1'b0;
    end else begin
      iresp_q <= 1'b0;
      dresp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_d) begin
            addr_q <= {bus.dcache_pmem_address[31:5], 5'd0};
            beat_q <= 2'd0;
            if (gnt_dw) begin
              state_q <= D_WRITE;
              wr_q    <= 1'b1;
              wline_q <= bus.dcache_pmem_wdata;
            end else begin
              state_q <= D_READ;
              rd_q    <= 1'b1;
            end
          end else if (gnt_i) begin
            addr_q  <= {bus.icache_pmem_address[31:5], 5'd0};
            beat_q  <= 2'd0;
            state_q <= I_READ;
            rd_q    <= 1'b1;
          end
        end
        I_READ, D_READ, D_WRITE: begin
          // Cycles without a memory response simply hold everything
          if (bus.pmem_resp) begin
            beat_q <= beat_q + 2'd1;
            if (state_q != D_WRITE) line_q <= line_d;
            if (beat_q == 2'd3) begin
              state_q <= DONE;
              rd_q    <= 1'b0;
              wr_q    <= 1'b0;
              if (state_q == I_READ) begin
                irdata_q <= line_d;
                iresp_q  <= 1'b1;
              end else begin
                dresp_q <= 1'b1;
                if (state_q == D_READ) drdata_q <= line_d;
              end
            end
          end
        end
        // One-cycle response slot; requesters drop here, so no grant is taken
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read         = rd_q;
  assign bus.pmem_write        = wr_q;
  assign bus.pmem_address      = addr_q;
  assign bus.pmem_wdata        = wr_q ? wline_q[{beat_q, 6'd0} +: 64] : 64'd0;
  assign bus.icache_pmem_rdata = irdata_q;
  assign bus.icache_pmem_resp  = iresp_q;
  assign bus.dcache_pmem_rdata = drdata_q;
  assign bus.dcache_pmem_resp  = dresp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: requester driver, burst memory model and a response
// scoreboard fed with expected line transfers at issue time.
module tb_cache_arbiter;
  localparam bit PRIO = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_arbiter_if bus();
  cache_arbiter #(.DCACHE_PRIORITY(PRIO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic         d;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  // memory model controls and capture of what the arbiter did on the bus
  int           wait_pct = 0;
  int           stall_beat = -1;
  int           stall_n = 0;
  bit           stray_en = 1'b0;
  bit           fixed_pat = 1'b0;
  int           mem_beat = 0;
  int           stall_cnt = 0;
  logic [31:0]  cap_addr = '0;
  logic         cap_wr = 1'b0;
  logic [255:0] cap_wline = '0;
  int           cap_beats = 0;
  logic         addr_bad = 1'b0;
  logic [255:0] last_i = '0;
  logic [255:0] last_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // contents the memory returns for beat b of the line at address a
  function automatic logic [63:0] memf(input logic [31:0] a, input int b);
    logic [7:0] v;
    if (fixed_pat) begin
      v = 8'(17 * (b + 1));
      return {8{v}};
    end
    return {a ^ (32'h9E37_79B9 * 32'(b + 1)), a + 32'(b) * 32'h0101_0101};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] l;
    for (int b = 0; b < 4; b++) l[b*64 +: 64] = memf(a, b);
    return l;
  endfunction

  // burst memory: responds (possibly late) to active strobes, records beats
  always @(negedge clk) begin
    if (!(bus.pmem_read || bus.pmem_write)) begin
      mem_beat       = 0;
      stall_cnt      = 0;
      bus.pmem_resp  = stray_en && ($urandom_range(3) == 0);
      bus.pmem_rdata = {$urandom, $urandom};
    end else begin
      chk("rd_wr_exclusive", bus.pmem_read && bus.pmem_write, 1'b0);
      bus.pmem_rdata = {$urandom, $urandom};
      if (mem_beat == stall_beat && stall_cnt < stall_n) begin
        stall_cnt++;
        bus.pmem_resp = 1'b0;
      end else if (int'($urandom_range(99)) < wait_pct) begin
        bus.pmem_resp = 1'b0;
      end else begin
        bus.pmem_resp = 1'b1;
        if (mem_beat == 0) begin
          cap_addr = bus.pmem_address;
          cap_wr   = bus.pmem_write;
          addr_bad = 1'b0;
        end else if (bus.pmem_address !== cap_addr) begin
          addr_bad = 1'b1;
        end
        if (bus.pmem_read) bus.pmem_rdata = memf(bus.pmem_address, mem_beat);
        else cap_wline[mem_beat*64 +: 64] = bus.pmem_wdata;
        mem_beat++;
        cap_beats = mem_beat;
      end
    end
  end

  // scoreboard monitor: every response pops and checks the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_i = '0;
      last_d = '0;
    end else if (bus.icache_pmem_resp || bus.dcache_pmem_resp) begin
      chk("one_resp", bus.icache_pmem_resp && bus.dcache_pmem_resp, 1'b0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_resp: got i=%0b d=%0b expected none", bus.icache_pmem_resp, bus.dcache_pmem_resp);
      end else begin
        e = sbq.pop_front();
        chk("resp_source", bus.dcache_pmem_resp, e.d);
        chk("pmem_addr", cap_addr, e.addr);
        chk("addr_stable", addr_bad, 1'b0);
        chk("beat_count", cap_beats, 4);
        chk("kind", cap_wr, e.wr);
        if (e.wr) chk("wdata_line", cap_wline, e.line);
        else if (e.d) begin
          chk("d_rdata", bus.dcache_pmem_rdata, e.line);
          last_d = e.line;
        end else begin
          chk("i_rdata", bus.icache_pmem_rdata, e.line);
          last_i = e.line;
        end
        if (e.d) chk("i_rdata_hold", bus.icache_pmem_rdata, last_i);
        else     chk("d_rdata_hold", bus.dcache_pmem_rdata, last_d);
      end
    end
  end

  task automatic drop_all();
    bus.icache_pmem_read  = 1'b0;
    bus.dcache_pmem_read  = 1'b0;
    bus.dcache_pmem_write = 1'b0;
  endtask

  // issue one or two requests, predict service order, hold until each resp
  task automatic do_txn(input bit ie, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [31:0] da, input logic [255:0] dwd,
                        input int exp_lat, input bit chk_gap);
    exp_t ei, ed;
    bit   ip, dp, seen_d, gap_done;
    int   c0, cd;
    ei.d = 1'b0; ei.wr = 1'b0; ei.addr = ia & 32'hFFFF_FFE0; ei.line = exp_line(ei.addr);
    ed.d = 1'b1; ed.wr = dw;   ed.addr = da & 32'hFFFF_FFE0;
    ed.line = dw ? dwd : exp_line(ed.addr);
    if (ie && (dr || dw)) begin
      if (PRIO) begin sbq.push_back(ed); sbq.push_back(ei); end
      else      begin sbq.push_back(ei); sbq.push_back(ed); end
    end else if (ie) sbq.push_back(ei);
    else if (dr || dw) sbq.push_back(ed);

    @(negedge clk);
    bus.icache_pmem_read    = ie;
    bus.icache_pmem_address = ia;
    bus.dcache_pmem_read    = dr;
    bus.dcache_pmem_write   = dw;
    bus.dcache_pmem_address = da;
    bus.dcache_pmem_wdata   = dwd;
    ip = ie; dp = dr || dw; c0 = cyc; seen_d = 0; gap_done = 0; cd = 0;
    for (int k = 0; k < 400 && (ip || dp); k++) begin
      @(negedge clk);
      if (chk_gap && seen_d && !gap_done && bus.pmem_read) begin
        chk("i_start_after_d_resp", cyc - cd, 2);
        gap_done = 1;
      end
      if (ip && bus.icache_pmem_resp) begin
        ip = 0;
        bus.icache_pmem_read = 1'b0;
        if (exp_lat > 0 && !(dr || dw)) chk("i_latency", cyc - c0 + 1, exp_lat);
      end
      if (dp && bus.dcache_pmem_resp) begin
        dp = 0;
        bus.dcache_pmem_read  = 1'b0;
        bus.dcache_pmem_write = 1'b0;
        seen_d = 1;
        cd = cyc;
        if (exp_lat > 0 && !ie) chk("d_latency", cyc - c0 + 1, exp_lat);
      end
    end
    if (ip || dp) begin
      n_chk++;
      n_err++;
      $display("FAIL txn_timeout: got pending i=%0b d=%0b expected none", ip, dp);
      drop_all();
      sbq.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] wl;
    bit ok;
    drop_all();
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;

    // reset: everything visible is zero
    #1 rst = 1'b0;
    #1;
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_pmem_write", bus.pmem_write, 1'b0);
    chk("rst_pmem_address", bus.pmem_address, 32'd0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 64'd0);
    chk("rst_i_resp", bus.icache_pmem_resp, 1'b0);
    chk("rst_d_resp", bus.dcache_pmem_resp, 1'b0);
    chk("rst_i_rdata", bus.icache_pmem_rdata, 256'd0);
    chk("rst_d_rdata", bus.dcache_pmem_rdata, 256'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // icache read of an unaligned address with the 0x11..0x44 beat pattern
    fixed_pat = 1'b1;
    do_txn(1, 32'h0000_0064, 0, 0, 32'd0, 256'd0, 6, 0);
    fixed_pat = 1'b0;
    wl = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    chk("i_line_pattern", bus.icache_pmem_rdata, wl);

    // dcache write, words W3..W0
    do_txn(0, 32'd0, 0, 1, 32'h0000_1000,
           {64'h3333_0000_3333_0003, 64'h2222_0000_2222_0002,
            64'h1111_0000_1111_0001, 64'h0000_AAAA_0000_0000}, 6, 0);

    // simultaneous reads: dcache first, icache starts two cycles after its resp
    do_txn(1, 32'h0000_2040, 1, 0, 32'h0000_3080, 256'd0, 0, 1);

    // read and write together on the dcache side: write wins
    do_txn(0, 32'd0, 1, 1, 32'h0000_40A0, {8{32'hC0DE_0001}}, 6, 0);

    // dcache read with two idle cycles before beat 2
    stall_beat = 2; stall_n = 2;
    do_txn(0, 32'd0, 1, 0, 32'h0000_5000, 256'd0, 8, 0);
    stall_beat = -1; stall_n = 0;

    // stray memory responses while idle change nothing
    stray_en = 1'b1;
    repeat (12) @(negedge clk);
    stray_en = 1'b0;
    chk("stray_i_rdata", bus.icache_pmem_rdata, last_i);
    chk("stray_d_rdata", bus.dcache_pmem_rdata, last_d);
    chk("stray_pmem_read", bus.pmem_read, 1'b0);

    // reset in the middle of an icache burst
    @(negedge clk);
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 32'h0000_7700;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk);
      #2;
      if (mem_beat >= 2) ok = 1;
    end
    chk("abort_reached_beat2", ok, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_pmem_read_async", bus.pmem_read, 1'b0);
    chk("abort_pmem_address", bus.pmem_address, 32'd0);
    chk("abort_i_rdata", bus.icache_pmem_rdata, 256'd0);
    chk("abort_i_resp", bus.icache_pmem_resp, 1'b0);
    bus.icache_pmem_read = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_resp", bus.icache_pmem_resp || bus.dcache_pmem_resp, 1'b0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resume", bus.pmem_read || bus.icache_pmem_resp, 1'b0);
    end
    do_txn(0, 32'd0, 1, 0, 32'h0000_8020, 256'd0, 6, 0);

    // randomized traffic with memory wait states and stray responses
    wait_pct = 25;
    stray_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int  kind;
      bit  dr, dw;
      kind = int'($urandom_range(2));
      dr = $urandom_range(1) == 1;
      dw = $urandom_range(1) == 1;
      if (!dr && !dw) dr = 1'b1;
      for (int w = 0; w < 8; w++) wl[w*32 +: 32] = $urandom;
      if (kind == 0) do_txn(1, $urandom, 0, 0, 32'd0, 256'd0, 0, 0);
      else if (kind == 1) do_txn(0, 32'd0, dr, dw, $urandom, wl, 0, 0);
      else do_txn(1, $urandom, dr, dw, $urandom, wl, 0, 0);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    stray_en = 1'b0;
    wait_pct = 0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
